conv3x3_stream_core: RTL

- Streaming 3x3 valid-mode convolution engine for the digit-recognition accelerator.
- Sits directly downstream of the Avalon-MM conv register interface: that interface writes kernel weights and start, streams 28x28 image pixels in, and collects results and done.
- Produces a 26x26 feature map in raster order using two line buffers and a 3x3 window register.

---
 rtl/conv3x3_stream_core.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/conv3x3_stream_core.sv
// Streaming 3x3 valid-mode convolution: two line buffers feed a 3x3 window, one result per completed window.
// Optional CONV_RELU_EN clamps negative sums to zero in the output register stage.
//
// state   | meaning
// S_IDLE  | waiting for start; weight writes allowed; counters held at 0
// S_RUN   | accepting pixels
// S_DRAIN | frame fully accepted, waiting for the last result to leave
// S_DONE  | one-cycle done pulse
module conv3x3_stream_core #(
   parameter int IMG_W = 28,
   parameter int IMG_H = 28,
   parameter int PIX_W = 8,
   parameter int WGT_W = 8,
   parameter int ACC_W = 21
) (
   input  logic             CLK,
   input  logic             RESET,
   input  logic             start,
   input  logic             wgt_we,
   input  logic [3:0]       wgt_addr,
   input  logic [WGT_W-1:0] wgt_data,
   input  logic             in_valid,
   input  logic [PIX_W-1:0] in_data,
   output logic             in_ready,
   output logic             out_valid,
   output logic [ACC_W-1:0] out_data,
   input  logic             out_ready,
   output logic             busy,
   output logic             done
);

   localparam int COL_W = $clog2(IMG_W);
   localparam int ROW_W = $clog2(IMG_H + 1);
   localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
   localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

   state_t                  state, state_nxt;
   logic [COL_W-1:0]        col;
   logic [ROW_W-1:0]        row;
   logic [PIX_W-1:0]        lb0 [IMG_W];
   logic [PIX_W-1:0]        lb1 [IMG_W];
   logic [PIX_W-1:0]        win [9];
   logic [PIX_W-1:0]        win_nxt [9];
   logic signed [WGT_W-1:0] wgt [9];
   logic                    pix_acc, last_pix, win_full;
   logic signed [ACC_W-1:0] acc, res;

   assign pix_acc  = in_valid && in_ready;
   assign last_pix = (row == ROW_LAST) && (col == COL_LAST);
   assign win_full = (row >= ROW_W'(2)) && (col >= COL_W'(2));

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) state <= S_IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (start) state_nxt = S_RUN;
         S_RUN:   if (pix_acc && last_pix) state_nxt = S_DRAIN;
         S_DRAIN: if (!out_valid || out_ready) state_nxt = S_DONE;
         S_DONE:  state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      in_ready = (state == S_RUN) && (!out_valid || out_ready);
      busy     = (state == S_RUN) || (state == S_DRAIN);
      done     = (state == S_DONE);
   end

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         col <= '0;
         row <= '0;
      end else if (state == S_IDLE) begin
         col <= '0;
         row <= '0;
      end else if (pix_acc) begin
         if (col == COL_LAST) begin
            col <= '0;
            row <= row + ROW_W'(1);
         end else begin
            col <= col + COL_W'(1);
         end
      end
   end

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         for (int i = 0; i < 9; i++) wgt[i] <= '0;
      end else if ((state == S_IDLE) && wgt_we && (wgt_addr < 4'd9)) begin
         wgt[wgt_addr] <= wgt_data;
      end
   end

   // Window index = row*3 + col, row 0 is the oldest image row.
   always_comb begin
      for (int r = 0; r < 3; r++) begin
         win_nxt[r*3]     = win[r*3+1];
         win_nxt[r*3 + 1] = win[r*3+2];
      end
      win_nxt[2] = lb1[col];
      win_nxt[5] = lb0[col];
      win_nxt[8] = in_data;
   end

   always_ff @(posedge CLK) begin
      if (pix_acc) begin
         lb1[col] <= lb0[col];
         lb0[col] <= in_data;
         for (int i = 0; i < 9; i++) win[i] <= win_nxt[i];
      end
   end

   always_comb begin
      acc = '0;
      for (int i = 0; i < 9; i++)
         acc = acc + ACC_W'($signed({1'b0, win_nxt[i]})) * ACC_W'(wgt[i]);
`ifdef CONV_RELU_EN
      res = acc[ACC_W-1] ? '0 : acc;
`else
      res = acc;
`endif
   end

   // A new result may overwrite the old one in the same cycle it is handed off.
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         out_valid <= 1'b0;
         out_data  <= '0;
      end else if (pix_acc && win_full) begin
         out_valid <= 1'b1;
         out_data  <= res;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

endmodule
